// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M unsigned MUL/MULHU/DIVU/REMU sequencer.
// Drives an external 4-bit-control ALU (add/sub only) and uses its carry
// flag for shift-add multiply and restoring division over 32 iterations.
// Optional macro MULDIV_FASTZERO_EN: a zero srcb skips CALC and goes to DONE.
module muldiv_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flags
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nxt;
    logic [4:0]  count;
    logic [1:0]  op_q;
    logic [31:0] hi, lo, d;
    logic [31:0] hi_nxt, lo_nxt;
    logic [31:0] r;
    logic        t, c, accept, zero_skip;
    logic [31:0] fast_res;
    logic        unused_flags;

    assign c            = alu_flags[2];
    assign unused_flags = ^{alu_flags[3], alu_flags[1:0]};
    assign r            = {hi[30:0], lo[31]};
    assign t            = hi[31];
    // start is only honoured between operations, never while iterating
    assign accept       = start && (state == IDLE || state == DONE);

`ifdef MULDIV_FASTZERO_EN
    assign zero_skip = (srcb == 32'd0);
    // zero-divisor / zero-multiplier results, identical to the iterative ones
    always_comb begin
        fast_res = 32'd0;
        case (op)
            2'b10:   fast_res = 32'hFFFF_FFFF;
            2'b11:   fast_res = srca;
            default: fast_res = 32'd0;
        endcase
    end
`else
    assign zero_skip = 1'b0;
    assign fast_res  = 32'd0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = zero_skip ? DONE : CALC;
            CALC:    if (count == 5'd0) state_nxt = DONE;
            DONE:    state_nxt = accept ? (zero_skip ? DONE : CALC) : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // outputs: handshake and ALU drive (ALU idles at add 0+0 outside CALC)
    always_comb begin
        busy     = (state == CALC);
        done     = (state == DONE);
        alu_a    = 32'd0;
        alu_b    = 32'd0;
        alu_ctrl = 4'b0000;
        if (state == CALC) begin
            alu_b = d;
            if (op_q[1]) begin
                alu_a    = r;
                alu_ctrl = 4'b0001;
            end else begin
                alu_a    = hi;
            end
        end
    end

    // one iteration step; carry is the add carry-out or the no-borrow bit
    always_comb begin
        hi_nxt = hi;
        lo_nxt = lo;
        if (op_q[1]) begin
            if (t | c) begin
                hi_nxt = alu_result;
                lo_nxt = {lo[30:0], 1'b1};
            end else begin
                hi_nxt = r;
                lo_nxt = {lo[30:0], 1'b0};
            end
        end else if (lo[0]) begin
            hi_nxt = {c, alu_result[31:1]};
            lo_nxt = {alu_result[0], lo[31:1]};
        end else begin
            hi_nxt = {1'b0, hi[31:1]};
            lo_nxt = {hi[0], lo[31:1]};
        end
    end

    // datapath registers; result is captured on the final iteration edge
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= 2'd0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            d      <= 32'd0;
            count  <= 5'd0;
            result <= 32'd0;
        end else if (accept) begin
            op_q  <= op;
            hi    <= 32'd0;
            lo    <= srca;
            d     <= srcb;
            count <= 5'd31;
            if (zero_skip) result <= fast_res;
        end else if (state == CALC) begin
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            count <= count - 5'd1;
            if (count == 5'd0) result <= op_q[0] ? hi_nxt : lo_nxt;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq with a behavioural ALU and a result scoreboard.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [1:0]  op;
    logic [31:0] srca, srcb;
    logic        busy, done;
    logic [31:0] result, alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctrl, alu_flags;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] sb[$];
    bit          mon_en = 1'b0;

`ifdef MULDIV_FASTZERO_EN
    localparam bit FASTZERO = 1'b1;
`else
    localparam bit FASTZERO = 1'b0;
`endif

    always #5 clk = ~clk;

    muldiv_seq dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
        .busy(busy), .done(done), .result(result), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_flags(alu_flags)
    );

    // reference ALU: add / sub with {v,c,n,z}
    logic [32:0] alu_sum;
    always_comb begin
        if (alu_ctrl == 4'b0001) alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        else                     alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = alu_sum[31:0];
        alu_flags  = {(alu_a[31] == (alu_b[31] ^ alu_ctrl[0])) && (alu_sum[31] != alu_a[31]),
                      alu_sum[32], alu_sum[31], alu_sum[31:0] == 32'd0};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (o)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // scoreboard and per-cycle invariants
    always @(negedge clk) begin
        if (mon_en) begin
            if (done && busy) chk("done_and_busy", {busy, done}, 2'b00);
            if (!busy) chk("alu_idle", {alu_ctrl, alu_a, alu_b} == 68'd0, 1'b1);
            if (alu_ctrl > 4'b0001) chk("alu_ctrl_range", {28'd0, alu_ctrl}, 32'd1);
            if (done) begin
                if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else                chk("result", result, sb.pop_front());
            end
        end
    end

    // one operation; optional stray start at cycle pulse_n; checks latency and busy span
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int pulse_n);
        int n, bcnt, lat;
        lat = (FASTZERO && b == 0) ? 1 : 33;
        @(negedge clk);
        start = 1'b1; op = o; srca = a; srcb = b;
        sb.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; op = ~o; srca = $urandom; srcb = $urandom;
        n = 1; bcnt = 0;
        while (!done && n < 40) begin
            if (busy) bcnt++;
            if (n == pulse_n) begin start = 1'b1; srca = 32'd11; srcb = 32'd13; end
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        chk("latency", n, lat);
        chk("busy_cycles", bcnt, lat - 1);
    endtask

    initial begin
        int n, bcnt;
        logic [31:0] a, b;
        logic [1:0]  o;
        reset = 1'b1; start = 1'b0; op = 2'd0; srca = 32'd0; srcb = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_result", result, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_ctrl", alu_ctrl, 4'd0);
        reset = 1'b0;
        mon_en = 1'b1;

        do_op(2'b00, 32'd7, 32'd6, 32'd42, 0);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        do_op(2'b10, 32'd100, 32'd7, 32'd14, 0);
        do_op(2'b11, 32'd100, 32'd7, 32'd2, 0);
        do_op(2'b10, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 0);
        do_op(2'b11, 32'h8000_0000, 32'd3, 32'd2, 0);
        do_op(2'b10, 32'h1234, 32'd0, 32'hFFFF_FFFF, 0);
        do_op(2'b11, 32'h1234, 32'd0, 32'h1234, 0);
        do_op(2'b01, 32'hDEAD_BEEF, 32'd0, 32'd0, 0);
        do_op(2'b00, 32'hDEAD_BEEF, 32'd0, 32'd0, 0);

        // stray start mid-operation must be ignored
        do_op(2'b00, 32'd7, 32'd6, 32'd42, 5);

        // abort with reset at edge k+10
        @(negedge clk);
        start = 1'b1; op = 2'b00; srca = 32'd5; srcb = 32'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_result", result, 32'd0);
        chk("abort_done", done, 1'b0);
        repeat (40) @(negedge clk);
        do_op(2'b00, 32'd3, 32'd3, 32'd9, 0);

        // start held through DONE: next op accepted with no IDLE cycle
        @(negedge clk);
        start = 1'b1; op = 2'b10; srca = 32'd1000; srcb = 32'd10;
        sb.push_back(32'd100);
        n = 0;
        while (!done && n < 40) begin @(negedge clk); n++; end
        chk("b2b_first_lat", n, 33);
        op = 2'b01; srca = 32'h1234_5678; srcb = 32'h9ABC_DEF0;
        sb.push_back(model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0));
        @(negedge clk);
        start = 1'b0;
        chk("b2b_no_idle", busy, 1'b1);
        n = 1; bcnt = 0;
        while (!done && n < 40) begin
            if (busy) bcnt++;
            @(negedge clk);
            n++;
        end
        chk("b2b_second_lat", n, 33);
        chk("b2b_busy", bcnt, 32);

        // random operands against the reference model
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom; o = 2'($urandom_range(0, 3));
            if (i == 5) b = 32'd1;
            do_op(o, a, b, model(o, a, b), 0);
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
